// File: rtl/fma16_pkg.sv
// fma16_pkg: shared state, opcode and width definitions for the fp16 FMA arbiter.
package fma16_pkg;

    localparam int FP_W   = 16;
    localparam int FLAG_W = 4;
    localparam int IDX_W  = 2;

    typedef logic [1:0] op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/fma16_rr_arb.sv
// fma16_rr_arb: round-robin selector. Searches upward from ptr with
// wrap-around and returns a one-hot grant plus the winning index.
module fma16_rr_arb
    import fma16_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    localparam int SW = IDX_W + 1;

    logic [SW-1:0] slot;

    // Walk the candidates starting at ptr and keep the first one that is requesting
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        slot  = '0;
        for (int k = 0; k < NREQ; k++) begin
            slot = {1'b0, ptr} + SW'(k);
            if (slot >= SW'(NREQ)) begin
                slot = slot - SW'(NREQ);
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (slot == SW'(j)) && req[j]) begin
                    grant[j] = 1'b1;
                    idx      = IDX_W'(j);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fma16_arb.sv
// fma16_arb: shares one external combinational fp16 unit among NREQ requesters.
// One operation in flight at a time: IDLE grants, EXEC drives the unit for LAT
// cycles, RESP holds the result until the owner takes it.
module fma16_arb
    import fma16_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LAT  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [FP_W*NREQ-1:0] req_x,
    input  logic [FP_W*NREQ-1:0] req_y,
    input  logic [FP_W*NREQ-1:0] req_z,
    input  logic [2*NREQ-1:0]    req_op,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [FP_W-1:0]      rsp_result,
    output logic [FLAG_W-1:0]    rsp_flags,
    output logic                 dp_valid,
    output logic [FP_W-1:0]      dp_x,
    output logic [FP_W-1:0]      dp_y,
    output logic [FP_W-1:0]      dp_z,
    output logic [1:0]           dp_op,
    input  logic [FP_W-1:0]      dp_result,
    input  logic [FLAG_W-1:0]    dp_flags,
    output logic                 busy,
    output logic [15:0]          op_count
);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  ptr, owner, win_idx;
    logic [NREQ-1:0]   grant;
    logic              win_any;
    logic [2:0]        cnt;
    logic              accept, capture, complete;
    logic              owner_ready;
    logic [FP_W-1:0]   sel_x, sel_y, sel_z;
    op_t               sel_op;

    fma16_rr_arb #(
        .NREQ (NREQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx),
        .found (win_any)
    );

    // Pick the winner's operand slices out of the packed request buses
    always_comb begin
        sel_x  = '0;
        sel_y  = '0;
        sel_z  = '0;
        sel_op = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant[j]) begin
                sel_x  = req_x[j*FP_W +: FP_W];
                sel_y  = req_y[j*FP_W +: FP_W];
                sel_z  = req_z[j*FP_W +: FP_W];
                sel_op = req_op[j*2 +: 2];
            end
        end
    end

    // Response strobe goes only to the owner; only the owner's rsp_ready matters
    always_comb begin
        rsp_valid   = '0;
        owner_ready = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (owner == IDX_W'(j)) begin
                rsp_valid[j] = (state == ST_RESP);
                owner_ready  = rsp_ready[j];
            end
        end
    end

    // Next-state decode plus the accept/capture/complete strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        complete  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_any) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt == 3'd0) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (owner_ready) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, latency counter, result capture, pointer and completion count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_x       <= '0;
            dp_y       <= '0;
            dp_z       <= '0;
            dp_op      <= '0;
            owner      <= '0;
            cnt        <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            ptr        <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                dp_x  <= sel_x;
                dp_y  <= sel_y;
                dp_z  <= sel_z;
                dp_op <= sel_op;
                owner <= win_idx;
                cnt   <= 3'(LAT - 1);
            end else if ((state == ST_EXEC) && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end
            if (capture) begin
                rsp_result <= dp_result;
                rsp_flags  <= dp_flags;
            end
            if (complete) begin
                op_count <= op_count + 16'd1;
                ptr      <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + IDX_W'(1);
            end
        end
    end

    assign req_ready = ((state == ST_IDLE) && reset_n) ? grant : '0;
    assign dp_valid  = (state == ST_EXEC);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_fma16_arb.sv
// tb_fma16_arb: scoreboard bench for fma16_arb with a behavioural fp16 unit on dp_*.
// dut_a: NREQ=2, LAT=1 (scoreboard-checked). dut_b: NREQ=3, LAT=3 (timing/pointer checks).
module tb_fma16_arb;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [1:0]  op;
        logic [15:0] res;
        logic [3:0]  flags;
    } vec_t;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  flags;
    } exp_t;

    // Directed vectors with hand-computed fp16 results (flags: invalid,overflow,underflow,inexact)
    function automatic vec_t get_vec(input int n);
        vec_t v;
        case (n)
            0:       v = '{16'h3C00, 16'h4000, 16'h0000, 2'd0, 16'h4000, 4'h0};
            1:       v = '{16'h4000, 16'h4200, 16'h3C00, 2'd0, 16'h4700, 4'h0};
            2:       v = '{16'h3C00, 16'h3C00, 16'h3C00, 2'd1, 16'hC000, 4'h0};
            3:       v = '{16'h7BFF, 16'h7BFF, 16'h0000, 2'd0, 16'h7C00, 4'h5};
            4:       v = '{16'h4000, 16'h4200, 16'h3C00, 2'd1, 16'hC700, 4'h0};
            default: v = '{16'h1234, 16'h5678, 16'h0000, 2'd2, 16'h7E00, 4'h8};
        endcase
        return v;
    endfunction

    // Behavioural fp16 FMA for the operands used here; opcode 1 negates the result
    function automatic logic [19:0] fp_model(input logic [15:0] x, input logic [15:0] y,
                                             input logic [15:0] z, input logic [1:0] op);
        logic [15:0] r;
        logic [3:0]  f;
        f = 4'h0;
        if (x == 16'h3C00 && y == 16'h4000 && z == 16'h0000)      r = 16'h4000;
        else if (x == 16'h4000 && y == 16'h4200 && z == 16'h3C00) r = 16'h4700;
        else if (x == 16'h3C00 && y == 16'h3C00 && z == 16'h3C00) r = 16'h4000;
        else if (x == 16'h7BFF && y == 16'h7BFF && z == 16'h0000) begin
            r = 16'h7C00;
            f = 4'h5;
        end else begin
            r = 16'h7E00;
            f = 4'h8;
        end
        if (op == 2'd1) r[15] = ~r[15];
        return {f, r};
    endfunction

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- dut_a signals ----------------
    logic        rv [2];
    logic [15:0] sx [2];
    logic [15:0] sy [2];
    logic [15:0] sz [2];
    logic [1:0]  sop [2];
    logic [1:0]  a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [31:0] a_req_x, a_req_y, a_req_z;
    logic [3:0]  a_req_op;
    logic [15:0] a_rsp_result;
    logic [3:0]  a_rsp_flags;
    logic        a_dp_valid;
    logic [15:0] a_dp_x, a_dp_y, a_dp_z;
    logic [1:0]  a_dp_op;
    logic [15:0] a_dp_result;
    logic [3:0]  a_dp_flags;
    logic        a_busy;
    logic [15:0] a_op_count;
    logic [19:0] a_m;

    assign a_req_valid = {rv[1], rv[0]};
    assign a_req_x     = {sx[1], sx[0]};
    assign a_req_y     = {sy[1], sy[0]};
    assign a_req_z     = {sz[1], sz[0]};
    assign a_req_op    = {sop[1], sop[0]};
    assign a_m         = fp_model(a_dp_x, a_dp_y, a_dp_z, a_dp_op);
    assign a_dp_result = a_dp_valid ? a_m[15:0]  : 16'hDEAD;
    assign a_dp_flags  = a_dp_valid ? a_m[19:16] : 4'hF;

    fma16_arb #(.NREQ(2), .LAT(1)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_x      (a_req_x),
        .req_y      (a_req_y),
        .req_z      (a_req_z),
        .req_op     (a_req_op),
        .rsp_valid  (a_rsp_valid),
        .rsp_ready  (a_rsp_ready),
        .rsp_result (a_rsp_result),
        .rsp_flags  (a_rsp_flags),
        .dp_valid   (a_dp_valid),
        .dp_x       (a_dp_x),
        .dp_y       (a_dp_y),
        .dp_z       (a_dp_z),
        .dp_op      (a_dp_op),
        .dp_result  (a_dp_result),
        .dp_flags   (a_dp_flags),
        .busy       (a_busy),
        .op_count   (a_op_count)
    );

    // ---------------- dut_b signals ----------------
    logic [2:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [47:0] b_req_x, b_req_y, b_req_z;
    logic [5:0]  b_req_op;
    logic [15:0] b_rsp_result;
    logic [3:0]  b_rsp_flags;
    logic        b_dp_valid;
    logic [15:0] b_dp_x, b_dp_y, b_dp_z;
    logic [1:0]  b_dp_op;
    logic [15:0] b_dp_result;
    logic [3:0]  b_dp_flags;
    logic        b_busy;
    logic [15:0] b_op_count;
    logic [19:0] b_m;

    assign b_m         = fp_model(b_dp_x, b_dp_y, b_dp_z, b_dp_op);
    assign b_dp_result = b_dp_valid ? b_m[15:0]  : 16'hDEAD;
    assign b_dp_flags  = b_dp_valid ? b_m[19:16] : 4'hF;

    fma16_arb #(.NREQ(3), .LAT(3)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_x      (b_req_x),
        .req_y      (b_req_y),
        .req_z      (b_req_z),
        .req_op     (b_req_op),
        .rsp_valid  (b_rsp_valid),
        .rsp_ready  (b_rsp_ready),
        .rsp_result (b_rsp_result),
        .rsp_flags  (b_rsp_flags),
        .dp_valid   (b_dp_valid),
        .dp_x       (b_dp_x),
        .dp_y       (b_dp_y),
        .dp_z       (b_dp_z),
        .dp_op      (b_dp_op),
        .dp_result  (b_dp_result),
        .dp_flags   (b_dp_flags),
        .busy       (b_busy),
        .op_count   (b_op_count)
    );

    // ---------------- scoreboard ----------------
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];
    int   grant_q [$];
    logic [15:0] exp_count = 16'd0;
    bit   cnt_pending = 1'b0;
    exp_t mon_e;
    int   mon_own;
    int   mon_g;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input int i, input exp_t e);
        if (i == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Monitor: grant order, response contents and op_count, sampled on the falling edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (cnt_pending) begin
                check("op_count", a_op_count, exp_count);
                cnt_pending = 1'b0;
            end
            if (a_req_ready != 2'b00) begin
                check("req_ready_onehot", $onehot(a_req_ready), 1);
                if (grant_q.size() > 0) begin
                    mon_g = grant_q.pop_front();
                    check("grant_order", a_req_ready, 32'd1 << mon_g);
                end
            end
            if (a_rsp_valid != 2'b00) begin
                check("rsp_valid_onehot", $onehot(a_rsp_valid), 1);
                mon_own = a_rsp_valid[1] ? 1 : 0;
                if (a_rsp_ready[mon_own]) begin
                    if ((mon_own == 0 && exp_q0.size() == 0) || (mon_own == 1 && exp_q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL rsp_unexpected actual=response_to_%0d required=none", mon_own);
                    end else begin
                        mon_e = (mon_own == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check("rsp_result", a_rsp_result, mon_e.res);
                        check("rsp_flags", a_rsp_flags, mon_e.flags);
                    end
                    exp_count   = exp_count + 16'd1;
                    cnt_pending = 1'b1;
                end
            end
        end
    end

    // Raise a request, wait (bounded) for its grant, drop it after the accepting edge
    task automatic issue(input int i, input int v, input bit expect_rsp, output int waits);
        vec_t t;
        t = get_vec(v);
        if (expect_rsp) push_exp(i, {t.res, t.flags});
        sx[i]  = t.x;
        sy[i]  = t.y;
        sz[i]  = t.z;
        sop[i] = t.op;
        rv[i]  = 1'b1;
        waits  = 0;
        @(negedge clk);
        while (!a_req_ready[i] && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        if (!a_req_ready[i]) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_timeout_r%0d actual=no_grant required=grant", i);
        end
        @(posedge clk);
        #1;
        rv[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (a_busy && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (a_busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout actual=busy required=idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n     = 1'b0;
        exp_count   = 16'd0;
        cnt_pending = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; sx[i] = '0; sy[i] = '0; sz[i] = '0; sop[i] = '0;
        end
        a_rsp_ready = 2'b11;
        b_req_valid = '0; b_req_x = '0; b_req_y = '0; b_req_z = '0; b_req_op = '0;
        b_rsp_ready = 3'b111;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_ready", a_req_ready, 0);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_rsp_result", a_rsp_result, 0);
        check("rst_rsp_flags", a_rsp_flags, 0);
        check("rst_dp_valid", a_dp_valid, 0);
        check("rst_dp_x", a_dp_x, 0);
        check("rst_busy", a_busy, 0);
        check("rst_op_count", a_op_count, 0);

        // Single op, accepted on the first edge after reset release
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        issue(0, 0, 1'b1, w);
        check("single_wait", w, 0);
        @(negedge clk);
        check("exec_dp_valid", a_dp_valid, 1);
        check("exec_dp_x", a_dp_x, 16'h3C00);
        check("exec_dp_y", a_dp_y, 16'h4000);
        check("exec_busy", a_busy, 1);
        check("exec_rsp_valid", a_rsp_valid, 0);
        @(negedge clk);
        check("single_rsp_valid", a_rsp_valid, 2'b01);
        check("resp_dp_valid", a_dp_valid, 0);
        @(negedge clk);
        check("single_busy_done", a_busy, 0);
        @(posedge clk);
        #1;

        // Both requesters continuously valid: grants alternate 0,1,0,1
        do_reset();
        grant_q.push_back(0); grant_q.push_back(1);
        grant_q.push_back(0); grant_q.push_back(1);
        fork
            begin
                int w0;
                issue(0, 1, 1'b1, w0);
                check("fair_wait_r0a", w0 <= 5, 1);
                issue(0, 2, 1'b1, w0);
                check("fair_wait_r0b", w0 <= 5, 1);
            end
            begin
                int w1;
                issue(1, 3, 1'b1, w1);
                check("fair_wait_r1a", w1 <= 5, 1);
                issue(1, 4, 1'b1, w1);
                check("fair_wait_r1b", w1 <= 5, 1);
            end
        join
        wait_idle();

        // Backpressure: owner holds rsp_ready low for 5 cycles, non-owner ready high
        grant_q.push_back(0); grant_q.push_back(1);
        a_rsp_ready = 2'b10;
        fork
            begin
                int wa;
                issue(0, 3, 1'b1, wa);
            end
            begin
                int wb;
                @(posedge clk);
                #1;
                issue(1, 5, 1'b1, wb);
            end
            begin
                int k;
                k = 0;
                @(negedge clk);
                while (!a_rsp_valid[0] && k < 20) begin
                    k++;
                    @(negedge clk);
                end
                for (int c = 0; c < 5; c++) begin
                    check("bp_rsp_valid", a_rsp_valid, 2'b01);
                    check("bp_rsp_result", a_rsp_result, 16'h7C00);
                    check("bp_rsp_flags", a_rsp_flags, 4'h5);
                    check("bp_no_grant", a_req_ready, 0);
                    if (c < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                a_rsp_ready[0] = 1'b1;
            end
        join
        wait_idle();
        a_rsp_ready = 2'b11;

        // Reset during EXEC: outputs return to reset values at once, r0 first afterwards
        issue(0, 0, 1'b1, w);
        wait_idle();
        issue(1, 1, 1'b0, w);
        #2;
        reset_n     = 1'b0;
        exp_count   = 16'd0;
        cnt_pending = 1'b0;
        #1;
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_dp_valid", a_dp_valid, 0);
        check("mid_rst_dp_x", a_dp_x, 0);
        check("mid_rst_rsp_valid", a_rsp_valid, 0);
        check("mid_rst_rsp_result", a_rsp_result, 0);
        check("mid_rst_op_count", a_op_count, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        grant_q.push_back(0); grant_q.push_back(1);
        fork
            begin
                int wc;
                issue(0, 4, 1'b1, wc);
            end
            begin
                int wd;
                issue(1, 5, 1'b1, wd);
            end
        join
        wait_idle();

        // op_count wrap from 0xFFFF
        force dut_a.op_count = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut_a.op_count;
        exp_count = 16'hFFFF;
        @(negedge clk);
        check("wrap_preload", a_op_count, 16'hFFFF);
        @(posedge clk);
        #1;
        issue(0, 1, 1'b1, w);
        wait_idle();
        check("wrap_op_count", a_op_count, 16'h0000);

        // dut_b: LAT=3 timing and pointer wrap over three requesters
        b_req_x[32 +: 16] = 16'h4000;
        b_req_y[32 +: 16] = 16'h4200;
        b_req_z[32 +: 16] = 16'h3C00;
        b_req_valid = 3'b100;
        @(negedge clk);
        check("b_grant_r2", b_req_ready, 3'b100);
        @(posedge clk);
        #1;
        b_req_valid = 3'b000;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("b_dp_valid_exec", b_dp_valid, 1);
            check("b_rsp_quiet", b_rsp_valid, 0);
        end
        @(negedge clk);
        check("b_dp_valid_resp", b_dp_valid, 0);
        check("b_rsp_valid", b_rsp_valid, 3'b100);
        check("b_rsp_result", b_rsp_result, 16'h4700);
        check("b_rsp_flags", b_rsp_flags, 4'h0);
        @(posedge clk);
        #1;
        b_req_x[16 +: 16] = 16'h3C00;
        b_req_y[16 +: 16] = 16'h4000;
        b_req_z[16 +: 16] = 16'h0000;
        b_req_valid = 3'b110;
        @(negedge clk);
        check("b_grant_ptr0", b_req_ready, 3'b010);
        @(posedge clk);
        #1;
        b_req_x[0 +: 16] = 16'h7BFF;
        b_req_y[0 +: 16] = 16'h7BFF;
        b_req_valid = 3'b101;
        @(negedge clk);
        check("b_no_grant_exec", b_req_ready, 0);
        repeat (3) @(negedge clk);
        check("b_rsp_valid_r1", b_rsp_valid, 3'b010);
        check("b_rsp_result_r1", b_rsp_result, 16'h4000);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b_grant_ptr2", b_req_ready, 3'b100);
        @(posedge clk);
        #1;
        b_req_valid = 3'b000;
        repeat (4) @(negedge clk);
        check("b_rsp_valid_r2", b_rsp_valid, 3'b100);
        @(negedge clk);
        check("b_op_count", b_op_count, 3);
        check("b_busy_done", b_busy, 0);

        check("sb_empty_r0", exp_q0.size(), 0);
        check("sb_empty_r1", exp_q1.size(), 0);
        check("grant_q_empty", grant_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
